// File: rtl/vai_serve_tx.sv
// VAI Tx merge: buffers CCI-P Tx traffic from every sub-AFU plus manager MMIO responses,
// arbitrates round-robin per channel, tags mdata with the VMID and relocates addresses.
package vai_pkg;
   typedef struct packed {
      logic [1:0]  vc_sel;
      logic [1:0]  cl_len;
      logic [3:0]  req_type;
      logic [41:0] address;
      logic [15:0] mdata;
   } t_ccip_c0_ReqMemHdr;

   typedef struct packed {
      logic [1:0]  vc_sel;
      logic        sop;
      logic [1:0]  cl_len;
      logic [3:0]  req_type;
      logic [41:0] address;
      logic [15:0] mdata;
   } t_ccip_c1_ReqMemHdr;

   typedef struct packed {
      logic [8:0] tid;
   } t_ccip_c2_RspMmioHdr;

   typedef struct packed {
      t_ccip_c0_ReqMemHdr hdr;
      logic               valid;
   } t_if_ccip_c0_Tx;

   typedef struct packed {
      t_ccip_c1_ReqMemHdr hdr;
      logic [511:0]       data;
      logic               valid;
   } t_if_ccip_c1_Tx;

   typedef struct packed {
      t_ccip_c2_RspMmioHdr hdr;
      logic                mmioRdValid;
      logic [63:0]         data;
   } t_if_ccip_c2_Tx;

   typedef struct packed {
      t_if_ccip_c0_Tx c0;
      t_if_ccip_c1_Tx c1;
      t_if_ccip_c2_Tx c2;
   } t_if_ccip_Tx;

   typedef struct packed {
      t_ccip_c1_ReqMemHdr hdr;
      logic [511:0]       data;
   } t_c1_ent;

   typedef struct packed {
      t_ccip_c2_RspMmioHdr hdr;
      logic [63:0]         data;
   } t_c2_ent;
endpackage

module vai_fifo #(
   parameter int W      = 8,
   parameter int DEPTH  = 8,
   parameter int AF_LVL = 5
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_din,
   output logic [W-1:0] o_dout,
   output logic         o_empty,
   output logic         o_afull
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [CW-1:0] r_cnt;
   logic          r_afull;
   logic          w_full, w_wr, w_rd;
   logic [CW-1:0] w_cnt_nxt;

   assign w_full    = (r_cnt == CW'(DEPTH));
   assign w_wr      = i_push && !w_full;
   assign w_rd      = i_pop && (r_cnt != '0);
   assign w_cnt_nxt = r_cnt + CW'(w_wr) - CW'(w_rd);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_cnt   <= '0;
         r_afull <= 1'b1;
      end else begin
         if (w_wr) r_wp <= r_wp + AW'(1);
         if (w_rd) r_rp <= r_rp + AW'(1);
         r_cnt   <= w_cnt_nxt;
         r_afull <= (w_cnt_nxt >= CW'(AF_LVL));
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wp] <= i_din;
   end

   assign o_dout  = r_mem[r_rp];
   assign o_empty = (r_cnt == '0);
   assign o_afull = r_afull;

   // Writing a full FIFO is a sender protocol violation; the write is dropped.
   a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(i_push && w_full));
endmodule

module vai_rr_arb #(
   parameter int N  = 8,
   parameter int IW = $clog2(N)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic [N-1:0]  i_req,
   input  logic          i_en,
   output logic          o_vld,
   output logic [IW-1:0] o_gnt
);
   logic [IW-1:0] r_ptr;
   logic [IW-1:0] w_idx;

   // Scan from the highest offset down so the requester nearest the pointer wins last.
   always_comb begin
      o_vld = 1'b0;
      o_gnt = r_ptr;
      w_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_idx = r_ptr + IW'(k);
         if (i_en && i_req[w_idx]) begin
            o_vld = 1'b1;
            o_gnt = w_idx;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n)   r_ptr <= '0;
      else if (o_vld) r_ptr <= o_gnt + IW'(1);
   end
endmodule

module vai_serve_tx
   import vai_pkg::*;
#(
   parameter int NUM_SUB_AFUS  = 8,
   parameter int FIFO_DEPTH    = 8,
   parameter int ALMFULL_SLACK = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  t_if_ccip_Tx             afu_TxPort   [NUM_SUB_AFUS],
   input  logic [63:0]             offset_array [NUM_SUB_AFUS],
   input  t_if_ccip_Tx             mgr_TxPort,
   input  logic                    up_c0TxAlmFull,
   input  logic                    up_c1TxAlmFull,
   output logic [NUM_SUB_AFUS-1:0] afu_c0TxAlmFull,
   output logic [NUM_SUB_AFUS-1:0] afu_c1TxAlmFull,
   output t_if_ccip_Tx             up_TxPort
);
   localparam int VMID_WIDTH = $clog2(NUM_SUB_AFUS);
   localparam int AF_LVL     = FIFO_DEPTH - ALMFULL_SLACK;

   t_ccip_c0_ReqMemHdr      w_c0_q [NUM_SUB_AFUS];
   t_c1_ent                 w_c1_q [NUM_SUB_AFUS];
   t_c2_ent                 w_c2_q [NUM_SUB_AFUS];
   logic [NUM_SUB_AFUS-1:0] w_c0_emp, w_c1_emp, w_c2_emp;
   logic [NUM_SUB_AFUS-1:0] w_c0_pop, w_c1_pop, w_c2_pop;
   logic [NUM_SUB_AFUS-1:0] w_c2_afull_unused;
   logic                    w_c0_vld, w_c1_vld, w_c2_vld;
   logic [VMID_WIDTH-1:0]   w_c0_gnt, w_c1_gnt, w_c2_gnt;

   for (genvar gi = 0; gi < NUM_SUB_AFUS; gi++) begin : g_afu
      vai_fifo #(.W($bits(t_ccip_c0_ReqMemHdr)), .DEPTH(FIFO_DEPTH), .AF_LVL(AF_LVL)) u_c0 (
         .i_clk(clk), .i_rst_n(reset),
         .i_push(afu_TxPort[gi].c0.valid), .i_pop(w_c0_pop[gi]),
         .i_din(afu_TxPort[gi].c0.hdr), .o_dout(w_c0_q[gi]),
         .o_empty(w_c0_emp[gi]), .o_afull(afu_c0TxAlmFull[gi]));

      vai_fifo #(.W($bits(t_c1_ent)), .DEPTH(FIFO_DEPTH), .AF_LVL(AF_LVL)) u_c1 (
         .i_clk(clk), .i_rst_n(reset),
         .i_push(afu_TxPort[gi].c1.valid), .i_pop(w_c1_pop[gi]),
         .i_din({afu_TxPort[gi].c1.hdr, afu_TxPort[gi].c1.data}), .o_dout(w_c1_q[gi]),
         .o_empty(w_c1_emp[gi]), .o_afull(afu_c1TxAlmFull[gi]));

      vai_fifo #(.W($bits(t_c2_ent)), .DEPTH(FIFO_DEPTH), .AF_LVL(AF_LVL)) u_c2 (
         .i_clk(clk), .i_rst_n(reset),
         .i_push(afu_TxPort[gi].c2.mmioRdValid), .i_pop(w_c2_pop[gi]),
         .i_din({afu_TxPort[gi].c2.hdr, afu_TxPort[gi].c2.data}), .o_dout(w_c2_q[gi]),
         .o_empty(w_c2_emp[gi]), .o_afull(w_c2_afull_unused[gi]));
   end

   // Manager MMIO responses: 2-entry buffer with absolute priority on c2.
   t_c2_ent    r_mgr [2];
   logic       r_mgr_wp, r_mgr_rp;
   logic [1:0] r_mgr_cnt;
   logic       w_mgr_push, w_mgr_pop;

   assign w_mgr_push = mgr_TxPort.c2.mmioRdValid && (r_mgr_cnt != 2'd2);
   assign w_mgr_pop  = (r_mgr_cnt != 2'd0);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_mgr_wp  <= 1'b0;
         r_mgr_rp  <= 1'b0;
         r_mgr_cnt <= 2'd0;
      end else begin
         if (w_mgr_push) r_mgr_wp <= ~r_mgr_wp;
         if (w_mgr_pop)  r_mgr_rp <= ~r_mgr_rp;
         r_mgr_cnt <= r_mgr_cnt + {1'b0, w_mgr_push} - {1'b0, w_mgr_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (w_mgr_push) r_mgr[r_mgr_wp] <= {mgr_TxPort.c2.hdr, mgr_TxPort.c2.data};
   end

   a_mgr_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(mgr_TxPort.c2.mmioRdValid && (r_mgr_cnt == 2'd2)));

   vai_rr_arb #(.N(NUM_SUB_AFUS)) u_arb_c0 (
      .i_clk(clk), .i_rst_n(reset), .i_req(~w_c0_emp), .i_en(!up_c0TxAlmFull),
      .o_vld(w_c0_vld), .o_gnt(w_c0_gnt));
   vai_rr_arb #(.N(NUM_SUB_AFUS)) u_arb_c1 (
      .i_clk(clk), .i_rst_n(reset), .i_req(~w_c1_emp), .i_en(!up_c1TxAlmFull),
      .o_vld(w_c1_vld), .o_gnt(w_c1_gnt));
   vai_rr_arb #(.N(NUM_SUB_AFUS)) u_arb_c2 (
      .i_clk(clk), .i_rst_n(reset), .i_req(~w_c2_emp), .i_en(r_mgr_cnt == 2'd0),
      .o_vld(w_c2_vld), .o_gnt(w_c2_gnt));

   assign w_c0_pop = w_c0_vld ? (NUM_SUB_AFUS'(1) << w_c0_gnt) : '0;
   assign w_c1_pop = w_c1_vld ? (NUM_SUB_AFUS'(1) << w_c1_gnt) : '0;
   assign w_c2_pop = w_c2_vld ? (NUM_SUB_AFUS'(1) << w_c2_gnt) : '0;

   // VMID tag replaces the top mdata bits; address relocates modulo 2^42.
   t_ccip_c0_ReqMemHdr w_c0_hdr;
   t_c1_ent            w_c1_ent;
   t_c2_ent            w_c2_ent;

   always_comb begin
      w_c0_hdr         = w_c0_q[w_c0_gnt];
      w_c0_hdr.address = w_c0_q[w_c0_gnt].address + offset_array[w_c0_gnt][41:0];
      w_c0_hdr.mdata[15 -: VMID_WIDTH] = w_c0_gnt;
   end

   always_comb begin
      w_c1_ent             = w_c1_q[w_c1_gnt];
      w_c1_ent.hdr.address = w_c1_q[w_c1_gnt].hdr.address + offset_array[w_c1_gnt][41:0];
      w_c1_ent.hdr.mdata[15 -: VMID_WIDTH] = w_c1_gnt;
   end

   assign w_c2_ent = w_mgr_pop ? r_mgr[r_mgr_rp] : w_c2_q[w_c2_gnt];

   t_if_ccip_Tx r_up;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_up <= '0;
      end else begin
         r_up.c0.valid       <= w_c0_vld;
         r_up.c0.hdr         <= w_c0_hdr;
         r_up.c1.valid       <= w_c1_vld;
         r_up.c1.hdr         <= w_c1_ent.hdr;
         r_up.c1.data        <= w_c1_ent.data;
         r_up.c2.mmioRdValid <= w_mgr_pop || w_c2_vld;
         r_up.c2.hdr         <= w_c2_ent.hdr;
         r_up.c2.data        <= w_c2_ent.data;
      end
   end

   assign up_TxPort = r_up;

   logic w_unused;
   always_comb begin
      w_unused = ^{mgr_TxPort.c0, mgr_TxPort.c1, w_c2_afull_unused};
      for (int i = 0; i < NUM_SUB_AFUS; i++) w_unused = w_unused ^ (^offset_array[i][63:42]);
   end
endmodule

// File: tb/tb_vai_serve_tx.sv
// Directed bench for vai_serve_tx: scoreboard queues filled at stimulus time, drained by a
// monitor that compares every upstream transfer in order.
module tb_vai_serve_tx;
   import vai_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   t_if_ccip_Tx afu_tx [8];
   logic [63:0] offs   [8];
   t_if_ccip_Tx mgr_tx;
   logic        up_c0_af, up_c1_af;
   logic [7:0]  af0, af1;
   t_if_ccip_Tx up_tx;

   vai_serve_tx #(.NUM_SUB_AFUS(8), .FIFO_DEPTH(8), .ALMFULL_SLACK(3)) dut (
      .clk(clk), .reset(reset), .afu_TxPort(afu_tx), .offset_array(offs),
      .mgr_TxPort(mgr_tx), .up_c0TxAlmFull(up_c0_af), .up_c1TxAlmFull(up_c1_af),
      .afu_c0TxAlmFull(af0), .afu_c1TxAlmFull(af1), .up_TxPort(up_tx));

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int n0 = 0, n1 = 0, n2 = 0;
   t_ccip_c0_ReqMemHdr q0[$];
   t_c1_ent            q1[$];
   t_c2_ent            q2[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Monitor samples 1 time unit after the edge; stimulus acts 2 after.
   always begin
      @(posedge clk);
      #1;
      if (up_tx.c0.valid === 1'b1) begin
         t_ccip_c0_ReqMemHdr e0;
         n0++;
         chk("c0_expected", 64'(q0.size() > 0), 64'd1);
         if (q0.size() > 0) begin
            e0 = q0.pop_front();
            checks++;
            assert (up_tx.c0.hdr === e0) else begin
               errors++;
               $error("FAIL c0_hdr got %h exp %h", up_tx.c0.hdr, e0);
            end
         end
      end
      if (up_tx.c1.valid === 1'b1) begin
         t_c1_ent e1;
         n1++;
         chk("c1_expected", 64'(q1.size() > 0), 64'd1);
         if (q1.size() > 0) begin
            e1 = q1.pop_front();
            checks++;
            assert ({up_tx.c1.hdr, up_tx.c1.data} === e1) else begin
               errors++;
               $error("FAIL c1_ent got %h exp %h", {up_tx.c1.hdr, up_tx.c1.data}, e1);
            end
         end
      end
      if (up_tx.c2.mmioRdValid === 1'b1) begin
         t_c2_ent e2;
         n2++;
         chk("c2_expected", 64'(q2.size() > 0), 64'd1);
         if (q2.size() > 0) begin
            e2 = q2.pop_front();
            checks++;
            assert ({up_tx.c2.hdr, up_tx.c2.data} === e2) else begin
               errors++;
               $error("FAIL c2_ent got %h exp %h", {up_tx.c2.hdr, up_tx.c2.data}, e2);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_valids();
      for (int i = 0; i < 8; i++) begin
         afu_tx[i].c0.valid       = 1'b0;
         afu_tx[i].c1.valid       = 1'b0;
         afu_tx[i].c2.mmioRdValid = 1'b0;
      end
      mgr_tx.c2.mmioRdValid = 1'b0;
   endtask

   function automatic t_ccip_c0_ReqMemHdr exp_c0(input t_ccip_c0_ReqMemHdr h, input int afu);
      t_ccip_c0_ReqMemHdr t;
      logic [63:0] o;
      t = h;
      o = offs[afu];
      t.address     = h.address + o[41:0];
      t.mdata[15:13] = 3'(afu);
      return t;
   endfunction

   function automatic t_ccip_c0_ReqMemHdr mk_c0(input logic [41:0] a, input logic [15:0] md);
      t_ccip_c0_ReqMemHdr h;
      h          = '0;
      h.vc_sel   = 2'b01;
      h.req_type = 4'h1;
      h.address  = a;
      h.mdata    = md;
      return h;
   endfunction

   task automatic drain(input string tag);
      for (int k = 0; k < 40 && (q0.size() + q1.size() + q2.size()) != 0; k++) step();
      chk(tag, 64'(q0.size() + q1.size() + q2.size()), 64'd0);
   endtask

   initial begin
      int base;
      t_ccip_c0_ReqMemHdr h0, e0;
      t_ccip_c1_ReqMemHdr h1;
      t_c1_ent            e1;
      t_c2_ent            e2;
      logic [511:0]       d1;

      reset    = 1'b0;
      up_c0_af = 1'b0;
      up_c1_af = 1'b0;
      mgr_tx   = '0;
      for (int i = 0; i < 8; i++) begin
         afu_tx[i] = '0;
         offs[i]   = '0;
      end

      // Reset state
      step(); step(); step();
      chk("rst_c0_valid", 64'(up_tx.c0.valid), 64'd0);
      chk("rst_c1_valid", 64'(up_tx.c1.valid), 64'd0);
      chk("rst_c2_valid", 64'(up_tx.c2.mmioRdValid), 64'd0);
      chk("rst_af0", 64'(af0), 64'hFF);
      chk("rst_af1", 64'(af1), 64'hFF);
      reset = 1'b1;
      step();
      chk("post_rst_af0", 64'(af0), 64'h00);
      chk("post_rst_af1", 64'(af1), 64'h00);

      // Round-robin: AFUs 0,3,7 each issue 4 c0 reads on the same cycles
      offs[0] = 64'h10; offs[3] = 64'h30; offs[7] = 64'h70;
      base = n0;
      for (int r = 0; r < 4; r++) begin
         foreach (afu_tx[a]) begin
            if (a == 0 || a == 3 || a == 7) begin
               h0 = mk_c0(42'h1000 + 42'(a * 256 + r), 16'(r * 16 + a));
               afu_tx[a].c0.hdr   = h0;
               afu_tx[a].c0.valid = 1'b1;
            end
         end
         foreach (afu_tx[a])
            if (a == 0 || a == 3 || a == 7)
               q0.push_back(exp_c0(mk_c0(42'h1000 + 42'(a * 256 + r), 16'(r * 16 + a)), a));
         step();
      end
      clear_valids();
      chk("rr_count_early", 64'(n0 - base), 64'd3);
      for (int k = 0; k < 9; k++) begin
         step();
         chk("rr_back_to_back", 64'(n0 - base), 64'(4 + k));
      end
      chk("rr_sb_empty", 64'(q0.size()), 64'd0);

      // Address/mdata rewrite and 2-cycle latency: AFU5 c0
      offs[5] = 64'h4000;
      h0 = mk_c0(42'h100, 16'h0123);
      afu_tx[5].c0.hdr   = h0;
      afu_tx[5].c0.valid = 1'b1;
      e0 = h0;
      e0.address = 42'h4100;
      e0.mdata   = 16'hA123;
      q0.push_back(e0);
      base = n0;
      step();
      clear_valids();
      chk("lat_not_1", 64'(n0 - base), 64'd0);
      step();
      chk("lat_2", 64'(n0 - base), 64'd1);

      // Address wrap on c1: AFU1, addr 0x3FF_FFFF_FFFF + 2
      offs[1] = 64'h2;
      h1 = '0;
      h1.sop     = 1'b1;
      h1.address = 42'h3FF_FFFF_FFFF;
      h1.mdata   = 16'h1ABC;
      d1 = {16{32'hDEAD_BEEF}} ^ {64{8'h5A}};
      afu_tx[1].c1.hdr   = h1;
      afu_tx[1].c1.data  = d1;
      afu_tx[1].c1.valid = 1'b1;
      e1.hdr         = h1;
      e1.hdr.address = 42'h1;
      e1.hdr.mdata   = 16'h3ABC;
      e1.data        = d1;
      q1.push_back(e1);
      base = n1;
      step();
      clear_valids();
      step();
      chk("wrap_c1_count", 64'(n1 - base), 64'd1);

      // Back-pressure: upstream c0 almost-full while AFU2 enqueues 5
      offs[2]  = 64'h8000;
      up_c0_af = 1'b1;
      base = n0;
      for (int r = 0; r < 5; r++) begin
         h0 = mk_c0(42'h200 + 42'(r), 16'h0040 + 16'(r));
         afu_tx[2].c0.hdr   = h0;
         afu_tx[2].c0.valid = 1'b1;
         q0.push_back(exp_c0(h0, 2));
         step();
         chk("bp_af0_2", 64'(af0[2]), 64'(r >= 4));
      end
      clear_valids();
      step(); step();
      chk("bp_no_issue", 64'(n0 - base), 64'd0);
      up_c0_af = 1'b0;
      drain("bp_drain");
      chk("bp_issued", 64'(n0 - base), 64'd5);
      chk("bp_af0_clear", 64'(af0), 64'h00);

      // c2 priority: mgr tid 0x11 vs AFU4 tid 0x22 on the same cycle
      mgr_tx.c2.hdr.tid        = 9'h11;
      mgr_tx.c2.data           = 64'hAAAA_5555_0000_1111;
      mgr_tx.c2.mmioRdValid    = 1'b1;
      afu_tx[4].c2.hdr.tid     = 9'h22;
      afu_tx[4].c2.data        = 64'hBBBB_CCCC_DDDD_EEEE;
      afu_tx[4].c2.mmioRdValid = 1'b1;
      e2.hdr.tid = 9'h11; e2.data = 64'hAAAA_5555_0000_1111; q2.push_back(e2);
      e2.hdr.tid = 9'h22; e2.data = 64'hBBBB_CCCC_DDDD_EEEE; q2.push_back(e2);
      base = n2;
      step();
      clear_valids();
      step();
      chk("c2_first", 64'(n2 - base), 64'd1);
      step();
      chk("c2_second", 64'(n2 - base), 64'd2);

      // Reset mid-stream with 3 entries queued behind upstream almost-full
      up_c0_af = 1'b1;
      for (int r = 0; r < 3; r++) begin
         afu_tx[6].c0.hdr   = mk_c0(42'h600 + 42'(r), 16'h0006);
         afu_tx[6].c0.valid = 1'b1;
         step();
      end
      clear_valids();
      step();
      reset = 1'b0;
      step(); step();
      chk("mid_rst_up_zero", 64'(up_tx === '0), 64'd1);
      chk("mid_rst_af0", 64'(af0), 64'hFF);
      chk("mid_rst_af1", 64'(af1), 64'hFF);
      reset    = 1'b1;
      up_c0_af = 1'b0;
      base = n0;
      for (int k = 0; k < 10; k++) step();
      chk("no_stale_after_rst", 64'(n0 - base), 64'd0);
      chk("final_sb_empty", 64'(q0.size() + q1.size() + q2.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/vai_serve_tx.md
Name: vai_serve_tx

Overview:
- Upstream-bound half of the VAI multiplexer. It merges CCI-P Tx traffic from NUM_SUB_AFUS sub-AFUs, plus the manager's MMIO read responses, onto the single upstream Tx port.
- On memory requests it:
  - tags mdata[15 -: VMID_WIDTH] with the originating VMID (the receive side later strips this tag);
  - relocates the cache-line address by that VM's offset_array entry.
- Per-AFU buffering, round-robin arbitration and almost-full back-pressure make the merge lossless.

Parameters:
NUM_SUB_AFUS, 8, number of sub-AFU Tx ports; power of two.
FIFO_DEPTH, 8, entries per AFU per channel (c0, c1, c2); power of two, >= 4.
ALMFULL_SLACK, 3, free entries remaining at which per-AFU almost-full asserts.
VMID_WIDTH (localparam), $clog2(NUM_SUB_AFUS).

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-low reset; 0 = reset asserted.
afu_TxPort  in  t_if_ccip_Tx [NUM_SUB_AFUS]  sub-AFU Tx requests (c0, c1, c2).
offset_array  in  64 [NUM_SUB_AFUS]  per-VM cache-line address offset.
mgr_TxPort  in  t_if_ccip_Tx  manager port; only c2 is used, c0/c1 are ignored.
up_c0TxAlmFull  in  1  upstream c0 almost-full.
up_c1TxAlmFull  in  1  upstream c1 almost-full.
afu_c0TxAlmFull  out  NUM_SUB_AFUS  per-AFU c0 back-pressure.
afu_c1TxAlmFull  out  NUM_SUB_AFUS  per-AFU c1 back-pressure.
up_TxPort  out  t_if_ccip_Tx  merged upstream Tx.

Behaviour:
- Reset (reset==0 at a clock edge):
  - all FIFOs are flushed and all arbiter pointers go to 0;
  - up_TxPort is all-zero (every valid = 0);
  - afu_c0TxAlmFull and afu_c1TxAlmFull are all-ones.
  - On the first cycle after reset deasserts, the almost-full outputs reflect empty FIFOs (0).
  - Reset asserted mid-operation discards all buffered requests; nothing partial is emitted.
- Enqueue: in every cycle, each valid afu_TxPort[i].cN is written into FIFO[i][N].
  - Writing into a full FIFO is a protocol violation. It is dropped, and an assertion fires in simulation.
- Per-AFU almost-full: afu_cNTxAlmFull[i] = (occupancy of FIFO[i][N] >= FIFO_DEPTH - ALMFULL_SLACK).
  - Registered; the value is based on the occupancy after the current cycle's write and read.
- Arbitration (stage A), one independent round-robin arbiter per channel:
  - c0 arbitrates only when up_c0TxAlmFull==0, and c1 only when up_c1TxAlmFull==0.
  - Each grant pops one entry.
  - The pointer advances to grant+1 mod NUM_SUB_AFUS.
  - c0 and c1 may both grant in the same cycle.
- c2 arbitration:
  - mgr_TxPort.c2 has absolute priority.
  - A valid mgr c2 is buffered in a dedicated 2-entry FIFO.
  - AFU c2 FIFOs are served round-robin only when the mgr FIFO is empty.
  - c2 ignores almost-full.
- Rewrite (stage A → output register), c0/c1 memory requests from AFU i:
  - hdr.address = afu address + offset_array[i][41:0], modulo 2^42, with carry discarded;
  - hdr.mdata[15 -: VMID_WIDTH] = i; the AFU's original top bits are overwritten;
  - hdr.mdata[15-VMID_WIDTH:0] is passed through unchanged;
  - all other header fields and c1 data are unchanged.
  - offset_array is sampled in the arbitration cycle.
- c2 rewrite: AFU c2 hdr.tid and data pass through unchanged.
- Output: up_TxPort is registered.
  - Latency from input valid to up_TxPort valid is 2 cycles when the FIFO is empty and the grant is uncontended.
  - Throughput is 1 request per channel per cycle.
- Ordering: FIFO order is preserved within one AFU and channel. There is no ordering guarantee across AFUs.
- Almost-full arriving in the same cycle as a pending grant suppresses that grant. Requests already registered still issue; CCI-P slack covers them.

Test Plan:
- Address and mdata rewrite: AFU5 c0 read, addr 0x100, mdata 0x0123, offset_array[5]=0x4000 → 2 cycles later up c0 valid, addr 0x4100, mdata 0xA123.
- Address wrap: AFU1 c1 write, addr 0x3FF_FFFF_FFFF, offset 0x2 → upstream addr 0x1, mdata[15:13]=1, data unchanged.
- Round-robin fairness: AFUs 0, 3 and 7 each issue 4 c0 requests in the same cycle → upstream grant order 0,3,7,0,3,7,...; 12 requests in 12 consecutive cycles.
- Back-pressure: up_c0TxAlmFull=1 while AFU2 streams c0 → no upstream c0; afu_c0TxAlmFull[2] rises after 5 enqueues. Releasing almost-full drains all 5 in order.
- c2 priority: mgr c2 (tid 0x11) and AFU4 c2 (tid 0x22) in the same cycle → tid 0x11 emitted first, 0x22 on the next cycle.
- Reset mid-stream: reset=0 with 3 entries queued → up_TxPort all-zero, almost-full all-ones. After release, no stale request is emitted.
